// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
// Grants one requester per IDLE->EXEC->RESP pass and returns its result with the winner's ID.
module logic_unit_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      win_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [1:0]           op_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 valid_q;
    logic [ID_W-1:0]      id_q;
    logic [WIDTH-1:0]     data_q;

    logic [ID_W-1:0]      win_d;
    logic [ID_W-1:0]      ptr_d;
    logic [WIDTH-1:0]     sel_a_d;
    logic [WIDTH-1:0]     sel_b_d;
    logic [1:0]           sel_op_d;
    logic [WIDTH-1:0]     result_d;
    logic                 found;
    logic [ID_W:0]        scan_idx;

    // Scan upward from the pointer, wrapping; one spare bit keeps the sum from overflowing.
    always_comb begin
        found    = 1'b0;
        win_d    = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[scan_idx[ID_W-1:0]]) begin
                found = 1'b1;
                win_d = scan_idx[ID_W-1:0];
            end
        end
    end

    assign ptr_d    = (win_d == ID_W'(NUM_REQ-1)) ? '0 : win_d + ID_W'(1);
    assign sel_a_d  = req_a[win_d*WIDTH +: WIDTH];
    assign sel_b_d  = req_b[win_d*WIDTH +: WIDTH];
    assign sel_op_d = req_op[win_d*2 +: 2];

    always_comb begin
        result_d = '0;
        case (op_q)
            2'b00:   result_d = a_q & b_q;
            2'b01:   result_d = a_q | b_q;
            2'b10:   result_d = a_q ^ b_q;
            default: result_d = ~(a_q & b_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        a_q          <= sel_a_d;
                        b_q          <= sel_b_d;
                        op_q         <= sel_op_d;
                        win_q        <= win_d;
                        gnt_q        <= '0;
                        gnt_q[win_d] <= 1'b1;
                        ptr_q        <= ptr_d;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    gnt_q   <= '0;
                    data_q  <= result_d;
                    id_q    <= win_q;
                    valid_q <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*2-1:0] req_op = '0;
    logic [N-1:0]   gnt;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int glog[$];
    int gcyc[$];

    // Transaction-level reference: who may be granted, what the pending answer is.
    bit       m_can  = 1'b1;
    bit       m_due  = 1'b0;
    bit       m_rv   = 1'b0;
    int       m_ptr  = 0;
    int       m_pid  = 0;
    int       m_pdat = 0;
    int       m_id   = 0;
    int       m_data = 0;
    int       m_gnt  = 0;

    logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int logic_op(input int a, input int b, input int op);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return (~(a & b)) & 8'hFF;
        endcase
    endfunction

    task automatic tick();
        logic [N-1:0]   s_req;
        logic [N*W-1:0] s_a, s_b;
        logic [N*2-1:0] s_op;
        logic           s_rdy, s_rst;
        bit             o_can, o_due, o_rv;
        int             w;
        s_req = req; s_a = req_a; s_b = req_b; s_op = req_op;
        s_rdy = resp_ready; s_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            m_can = 1'b1; m_due = 1'b0; m_rv = 1'b0; m_ptr = 0;
            m_id = 0; m_data = 0; m_gnt = 0;
        end else begin
            o_can = m_can; o_due = m_due; o_rv = m_rv;
            m_gnt = 0;
            if (o_can && s_req != 0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && s_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                m_gnt  = 1 << w;
                m_ptr  = (w + 1) % N;
                m_pid  = w;
                m_pdat = logic_op(int'(s_a[w*W +: W]), int'(s_b[w*W +: W]), int'(s_op[w*2 +: 2]));
                m_can  = 1'b0;
                m_due  = 1'b1;
            end
            if (o_due) begin
                m_rv = 1'b1; m_due = 1'b0; m_id = m_pid; m_data = m_pdat;
            end
            if (o_rv && s_rdy) begin
                m_rv = 1'b0; m_can = 1'b1;
            end
        end
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("resp_valid", 32'(resp_valid), 32'(m_rv));
        chk("resp_id", 32'(resp_id), 32'(m_id));
        chk("resp_data", 32'(resp_data), 32'(m_data));
        for (int i = 0; i < N; i++) begin
            if (gnt === N'(1 << i)) begin
                glog.push_back(i);
                gcyc.push_back(cyc);
            end
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*2 +: 2] = op;
    endtask

    task automatic wait_gnt(input int maxc, input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 0 && n < maxc);
        chk(nm, 32'(gnt != 0), 32'd1);
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_valid && n < maxc);
        chk(nm, 32'(resp_valid), 32'd1);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] held_d;
        logic [1:0] held_id;
        int         gsz;

        vecs[0] = '{0, 8'hF0, 8'h3C, 2'b00, 8'h30};
        vecs[1] = '{2, 8'hAA, 8'h0F, 2'b01, 8'hAF};
        vecs[2] = '{2, 8'hAA, 8'h0F, 2'b10, 8'hA5};
        vecs[3] = '{2, 8'hAA, 8'h0F, 2'b11, 8'hF5};
        vecs[4] = '{3, 8'hFF, 8'hFF, 2'b11, 8'h00};
        vecs[5] = '{1, 8'h5A, 8'hA5, 2'b10, 8'hFF};

        // Reset then idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_data", 32'(resp_data), 32'd0);

        // Single-requester vectors, including the full opcode sweep
        resp_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
            req = N'(1 << vecs[v].idx);
            wait_gnt(6, "vec_gnt_timeout");
            chk("vec_gnt", 32'(gnt), 32'(1 << vecs[v].idx));
            req = '0;
            wait_valid(4, "vec_valid_timeout");
            chk("vec_id", 32'(resp_id), 32'(vecs[v].idx));
            chk("vec_data", 32'(resp_data), 32'(vecs[v].exp));
        end
        tick(); tick();

        // Fairness with all requesters, then 1010
        rst = 1'b1; tick(); rst = 1'b0;
        glog.delete(); gcyc.delete();
        req = 4'hF;
        for (int i = 0; i < 15; i++) tick();
        chk("fair_count", 32'(glog.size()), 32'd5);
        if (glog.size() >= 5) begin
            chk("fair_0", 32'(glog[0]), 32'd0);
            chk("fair_1", 32'(glog[1]), 32'd1);
            chk("fair_2", 32'(glog[2]), 32'd2);
            chk("fair_3", 32'(glog[3]), 32'd3);
            chk("fair_4", 32'(glog[4]), 32'd0);
            for (int i = 0; i < 4; i++) chk("fair_gap", 32'(gcyc[i+1] - gcyc[i]), 32'd3);
        end
        req = 4'b1010;
        for (int i = 0; i < 7; i++) tick();
        chk("wrap_count", 32'(glog.size() >= 7), 32'd1);
        if (glog.size() >= 7) begin
            chk("wrap_1", 32'(glog[5]), 32'd1);
            chk("wrap_3", 32'(glog[6]), 32'd3);
        end
        req = '0;
        tick(); tick(); tick();

        // Backpressure
        resp_ready = 1'b0;
        req = 4'hF;
        wait_valid(8, "bp_valid_timeout");
        held_d  = resp_data;
        held_id = resp_id;
        gsz     = glog.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", 32'(resp_data), 32'(held_d));
            chk("bp_id", 32'(resp_id), 32'(held_id));
        end
        chk("bp_no_gnt", 32'(glog.size()), 32'(gsz));
        resp_ready = 1'b1;
        tick();
        chk("bp_release", 32'(resp_valid), 32'd0);
        tick();
        chk("bp_next_gnt", 32'(gnt != 0), 32'd1);
        req = '0;
        tick(); tick(); tick();

        // Reset during EXEC and during RESP
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'hF;
        wait_gnt(4, "rx_gnt_timeout");
        rst = 1'b1; tick();
        chk("rx_exec_valid", 32'(resp_valid), 32'd0);
        chk("rx_exec_gnt", 32'(gnt), 32'd0);
        rst = 1'b0; tick();
        chk("rx_exec_regnt", 32'(gnt), 32'd1);
        resp_ready = 1'b0;
        wait_valid(4, "rx_valid_timeout");
        rst = 1'b1; tick();
        chk("rx_resp_valid", 32'(resp_valid), 32'd0);
        chk("rx_resp_gnt", 32'(gnt), 32'd0);
        rst = 1'b0; tick();
        chk("rx_resp_regnt", 32'(gnt), 32'd1);
        req = '0; resp_ready = 1'b1;
        tick(); tick(); tick();

        // Randomized traffic against the reference
        for (int i = 0; i < 500; i++) begin
            req        = N'($urandom_range(0, 15));
            req_a      = $urandom;
            req_b      = $urandom;
            req_op     = 8'($urandom_range(0, 255));
            resp_ready = ($urandom_range(0, 9) < 7);
            rst        = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters.
- Each requester presents its operands and an opcode. The arbiter picks one in round-robin order, captures its inputs, computes the result, and returns it with the winner's ID over a valid/ready response channel.
- Sits between the gate-level logic primitives and the lab's requester modules. It is the single point of sequencing for the shared logic datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), derived localparam, not overridable; width of resp_id.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  NUM_REQ  level request, one bit per requester.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_op  input  NUM_REQ*2  opcode; requester i occupies [i*2 +: 2]. 00 AND, 01 OR, 10 XOR, 11 NAND.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: the winner's operands have been captured.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that owns resp_data.
- resp_data  output  WIDTH  result of the operation.

Behaviour:
- Reset (rst high at a clock edge) clears state and outputs:
  - state = IDLE, gnt = 0, resp_valid = 0, resp_id = 0, resp_data = 0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - Reset wins over every other event, including an in-flight EXEC or an unaccepted RESP. The pending result is discarded.
- FSM: IDLE -> EXEC -> RESP -> IDLE. gnt, resp_valid, resp_id and resp_data are all registered outputs.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select winner w: the first set req bit scanning upward from pointer, wrapping from NUM_REQ-1 to 0.
  - At the edge: latch req_a[w], req_b[w], req_op[w] and w; set gnt[w] = 1; pointer <= (w+1) mod NUM_REQ; go to EXEC.
- EXEC:
  - gnt is high for exactly this cycle.
  - At the edge: gnt <= 0; resp_data <= op(a_q, b_q); resp_id <= w; resp_valid <= 1; go to RESP.
  - NAND is the bitwise ~(a & b) over all WIDTH bits; the result width is WIDTH with no carry.
- RESP:
  - resp_valid, resp_id and resp_data are held stable while resp_ready is low. There is no timeout.
  - On an edge with resp_ready high: resp_valid <= 0 and go to IDLE. resp_data and resp_id keep their last value.
- Latency: a request sampled at edge t gives gnt high in cycle t+1 and resp_valid high from cycle t+2. The earliest back-to-back grant is sampled at edge t+3, so peak throughput is one operation per 3 cycles.
- Requester contract:
  - Deassert req in the cycle gnt is seen, or it will be re-arbitrated in turn.
  - Operands only need to be stable in the IDLE cycle in which the grant is decided.
- Boundary cases:
  - req changes in EXEC or RESP: ignored; only the IDLE sample matters.
  - All requesters active: strict rotation 0,1,2,...,NUM_REQ-1,0,...
  - A single requester holding req continuously: it is granted every 3 cycles.
  - resp_ready held high permanently: RESP lasts exactly one cycle.
  - resp_ready high outside RESP: no effect.
  - Opcode and operands for non-winners: never observed.

Test Plan:
- Reset then idle: rst high for 2 cycles, req = 0 for 10 cycles -> gnt = 0, resp_valid = 0, resp_data = 0 throughout.
- Single AND op: req = 0001, a0 = 8'hF0, b0 = 8'h3C, op0 = 00, resp_ready = 1 -> gnt = 0001 one cycle after sampling; next cycle resp_valid = 1, resp_id = 0, resp_data = 8'h30.
- Opcode sweep on requester 2, a = 8'hAA, b = 8'h0F:
  - OR -> 8'hAF
  - XOR -> 8'hA5
  - NAND -> 8'hF5
  - Each response has resp_id = 2.
- Fairness: req = 1111 held, resp_ready = 1 -> grant order 0,1,2,3,0, one grant every 3 cycles. Then req = 1010 -> the next two grants are 1 and 3, wrapping correctly.
- Backpressure: resp_ready = 0 for 5 cycles with a result pending -> resp_valid, resp_id and resp_data stay constant and no new gnt is issued even with req = 1111. Raising resp_ready -> one transfer, then the next grant.
- Reset mid-operation: assert rst during EXEC and during RESP -> the next cycle has resp_valid = 0 and gnt = 0, and the first grant after release goes to requester 0 when req = 1111.
